// File: rtl/hazard_scoreboard.sv
// Decode-stage interlock: per-register countdowns until a writer's result is forwardable.
// hazard_stall is combinational from registered state; state updates on the issue edge.
module hazard_scoreboard #(
   parameter int LOAD_LAT = 2,
   parameter int WB_LAT   = 3,
   parameter int CNT_W    = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       stall_all,
   input  logic       flush,
   input  logic       issue_valid,
   input  logic       ld_regfile,
   input  logic [2:0] dest_reg,
   input  logic       byte_read,
   input  logic       word_read,
   input  logic       trap_instr,
   input  logic       sr1_used,
   input  logic [2:0] sr1_reg,
   input  logic       sr2_used,
   input  logic [2:0] sr2_reg,
   output logic       hazard_stall,
   output logic       issue_fire,
   output logic [7:0] pending_mask,
   output logic [15:0] stall_count
);

   logic [CNT_W-1:0] cnt [8];
   logic [CNT_W-1:0] issue_lat;
   logic             is_load;

   assign is_load = byte_read || word_read;

   always_comb begin
      issue_lat = '0;
      if (trap_instr)
         issue_lat = CNT_W'(WB_LAT);
      else if (is_load)
         issue_lat = CNT_W'(LOAD_LAT);
   end

   assign hazard_stall = issue_valid && !flush &&
                         ((sr1_used && (cnt[sr1_reg] != '0)) ||
                          (sr2_used && (cnt[sr2_reg] != '0)));

   assign issue_fire = issue_valid && !hazard_stall && !stall_all && !flush;

   always_comb begin
      pending_mask = '0;
      for (int r = 0; r < 8; r++)
         pending_mask[r] = (cnt[r] != '0);
   end

   // The newest writer's latency overrides that entry's decrement (WAW).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < 8; r++)
            cnt[r] <= '0;
      end else if (flush) begin
         for (int r = 0; r < 8; r++)
            cnt[r] <= '0;
      end else if (!stall_all) begin
         for (int r = 0; r < 8; r++) begin
            if (issue_fire && ld_regfile && (dest_reg == 3'(r)))
               cnt[r] <= issue_lat;
            else if (cnt[r] != '0)
               cnt[r] <= cnt[r] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         stall_count <= '0;
      else if (hazard_stall && !stall_all && !flush && (stall_count != 16'hFFFF))
         stall_count <= stall_count + 16'd1;
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table plus hand sequences for reset.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       stall_all, flush, issue_valid, ld_regfile;
   logic [2:0] dest_reg, sr1_reg, sr2_reg;
   logic       byte_read, word_read, trap_instr, sr1_used, sr2_used;
   logic       hazard_stall, issue_fire;
   logic [7:0] pending_mask;
   logic [15:0] stall_count;

   int checks = 0;
   int failures = 0;
   int sc_exp = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.LOAD_LAT(2), .WB_LAT(3), .CNT_W(2)) dut (
      .clk(clk), .reset_n(reset_n), .stall_all(stall_all), .flush(flush),
      .issue_valid(issue_valid), .ld_regfile(ld_regfile), .dest_reg(dest_reg),
      .byte_read(byte_read), .word_read(word_read), .trap_instr(trap_instr),
      .sr1_used(sr1_used), .sr1_reg(sr1_reg), .sr2_used(sr2_used), .sr2_reg(sr2_reg),
      .hazard_stall(hazard_stall), .issue_fire(issue_fire),
      .pending_mask(pending_mask), .stall_count(stall_count)
   );

   // kind: 0 ALU, 1 byte load, 2 word load, 3 trap
   typedef struct {
      logic       sa, fl, iv, ld;
      logic [2:0] dst;
      logic [1:0] kind;
      logic       s1u;
      logic [2:0] s1;
      logic       s2u;
      logic [2:0] s2;
      logic       e_stall, e_fire;
      logic [7:0] e_mask;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic sa, logic fl, logic iv, logic ld, logic [2:0] dst,
                               logic [1:0] kind, logic s1u, logic [2:0] s1, logic s2u,
                               logic [2:0] s2, logic es, logic ef, logic [7:0] em);
      vec_t v;
      v.sa = sa; v.fl = fl; v.iv = iv; v.ld = ld; v.dst = dst; v.kind = kind;
      v.s1u = s1u; v.s1 = s1; v.s2u = s2u; v.s2 = s2;
      v.e_stall = es; v.e_fire = ef; v.e_mask = em;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      stall_all   = v.sa;
      flush       = v.fl;
      issue_valid = v.iv;
      ld_regfile  = v.ld;
      dest_reg    = v.dst;
      byte_read   = (v.kind == 2'd1);
      word_read   = (v.kind == 2'd2);
      trap_instr  = (v.kind == 2'd3);
      sr1_used    = v.s1u;
      sr1_reg     = v.s1;
      sr2_used    = v.s2u;
      sr2_reg     = v.s2;
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      drive(v);
      #2;
      chk("hazard_stall", idx, 32'(hazard_stall), 32'(v.e_stall));
      chk("issue_fire", idx, 32'(issue_fire), 32'(v.e_fire));
      chk("pending_mask", idx, 32'(pending_mask), 32'(v.e_mask));
      chk("stall_count", idx, 32'(stall_count), 32'(sc_exp));
      if (v.e_stall && !v.sa && !v.fl)
         sc_exp++;
   endtask

   initial begin
      // ADD R1; ADD R2,R1,R1
      vecs.push_back(mk(0,0,1,1,1,0, 1,0,1,0, 0,1,8'h00));
      vecs.push_back(mk(0,0,1,1,2,0, 1,1,1,1, 0,1,8'h00));
      // LDR R3; ADD R4,R3 stalls two cycles
      vecs.push_back(mk(0,0,1,1,3,2, 1,6,0,0, 0,1,8'h00));
      vecs.push_back(mk(0,0,1,1,4,0, 1,3,0,0, 1,0,8'h08));
      vecs.push_back(mk(0,0,1,1,4,0, 1,3,0,0, 1,0,8'h08));
      vecs.push_back(mk(0,0,1,1,4,0, 1,3,0,0, 0,1,8'h00));
      // TRAP -> R7; JMP R7 stalls three cycles
      vecs.push_back(mk(0,0,1,1,7,3, 0,0,0,0, 0,1,8'h00));
      vecs.push_back(mk(0,0,1,0,0,0, 1,7,0,0, 1,0,8'h80));
      vecs.push_back(mk(0,0,1,0,0,0, 1,7,0,0, 1,0,8'h80));
      vecs.push_back(mk(0,0,1,0,0,0, 1,7,0,0, 1,0,8'h80));
      vecs.push_back(mk(0,0,1,0,0,0, 1,7,0,0, 0,1,8'h00));
      // WAW: ALU write to R3 cancels pending byte load
      vecs.push_back(mk(0,0,1,1,3,1, 1,6,0,0, 0,1,8'h00));
      vecs.push_back(mk(0,0,1,1,3,0, 1,0,0,0, 0,1,8'h08));
      vecs.push_back(mk(0,0,1,1,4,0, 0,0,1,3, 0,1,8'h00));
      // stall_all freezes countdown and stall_count
      vecs.push_back(mk(0,0,1,1,5,2, 1,6,0,0, 0,1,8'h00));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(1,0,1,1,4,0, 1,5,0,0, 1,0,8'h20));
      vecs.push_back(mk(0,0,1,1,4,0, 1,5,0,0, 1,0,8'h20));
      vecs.push_back(mk(0,0,1,1,4,0, 1,5,0,0, 1,0,8'h20));
      vecs.push_back(mk(0,0,1,1,4,0, 1,5,0,0, 0,1,8'h00));
      // flush squashes pending load
      vecs.push_back(mk(0,0,1,1,2,2, 1,6,0,0, 0,1,8'h00));
      vecs.push_back(mk(0,1,1,1,4,0, 1,2,0,0, 0,0,8'h04));
      vecs.push_back(mk(0,0,1,1,4,0, 1,2,0,0, 0,1,8'h00));
      // self-dependency uses old count; flush beats stall_all
      vecs.push_back(mk(0,0,1,1,1,2, 1,1,0,0, 0,1,8'h00));
      vecs.push_back(mk(1,1,0,0,0,0, 0,0,0,0, 0,0,8'h02));
      vecs.push_back(mk(0,0,1,1,4,0, 1,1,0,0, 0,1,8'h00));
      // store (no ld_regfile) leaves dest untouched
      vecs.push_back(mk(0,0,1,0,6,2, 1,2,1,6, 0,1,8'h00));
      vecs.push_back(mk(0,0,1,1,4,0, 1,6,0,0, 0,1,8'h00));
      // unused source field and invalid decode never stall
      vecs.push_back(mk(0,0,1,1,3,2, 1,6,0,0, 0,1,8'h00));
      vecs.push_back(mk(0,0,1,1,5,0, 0,3,0,3, 0,1,8'h08));
      vecs.push_back(mk(0,0,0,0,0,0, 1,3,0,0, 0,0,8'h08));
      vecs.push_back(mk(0,0,1,1,4,0, 1,3,0,0, 0,1,8'h00));

      reset_n = 1'b0;
      drive(mk(0,0,0,0,0,0, 0,0,0,0, 0,0,8'h00));
      #3;
      chk("rst_stall", -1, 32'(hazard_stall), 32'd0);
      chk("rst_fire", -1, 32'(issue_fire), 32'd0);
      chk("rst_mask", -1, 32'(pending_mask), 32'd0);
      chk("rst_stall_count", -1, 32'(stall_count), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i], i);

      chk("stall_count_total", -2, 32'(stall_count), 32'd7);

      // Asynchronous reset mid-countdown
      apply(mk(0,0,1,1,3,2, 1,6,0,0, 0,1,8'h00), 100);
      apply(mk(0,0,1,1,4,0, 1,3,0,0, 1,0,8'h08), 101);
      #4;
      chk("pre_rst_count", 102, 32'(stall_count), 32'd8);
      reset_n = 1'b0;
      #1;
      chk("arst_mask", 102, 32'(pending_mask), 32'd0);
      chk("arst_stall", 102, 32'(hazard_stall), 32'd0);
      chk("arst_stall_count", 102, 32'(stall_count), 32'd0);
      chk("arst_fire", 102, 32'(issue_fire), 32'd1);
      sc_exp = 0;
      @(negedge clk);
      drive(mk(0,0,0,0,0,0, 0,0,0,0, 0,0,8'h00));
      reset_n = 1'b1;
      apply(mk(0,0,1,1,4,0, 1,3,0,0, 0,1,8'h00), 103);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Decode-stage interlock sitting directly upstream of the execute stage and its operand forwarding logic. Tracks per-register "not yet forwardable" countdowns for in-flight writers and raises a stall so that no instruction enters execute before its sources can be supplied by the forwarding paths or the register file. ALU-class results are forwardable immediately and never stall. Loads stall until the memory-stage forward exists. Trap-vector loads, which are never forwarded, stall until writeback.

Parameters:
LOAD_LAT, 2, cycles after issue before a byte/word load result becomes forwardable from the memory stage
WB_LAT, 3, cycles after issue before a trap-load result is readable from the register file
CNT_W, 2, width of each per-register countdown; must satisfy 2^CNT_W-1 >= max(LOAD_LAT, WB_LAT)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
stall_all  input  1  global pipeline freeze from the memory stage
flush  input  1  branch/trap redirect; squashes all in-flight writers
issue_valid  input  1  decode holds a valid instruction
ld_regfile  input  1  decoded instruction writes dest_reg
dest_reg  input  3  destination register
byte_read  input  1  decoded instruction is a byte load
word_read  input  1  decoded instruction is a word load
trap_instr  input  1  decoded instruction is TRAP (vector load)
sr1_used  input  1  instruction reads sr1_reg (ALU operand, store base, JMP/JSRR base)
sr1_reg  input  3  source 1
sr2_used  input  1  instruction reads sr2_reg (register-mode ALU, store data)
sr2_reg  input  3  source 2
hazard_stall  output  1  hold decode/fetch and inject a bubble into execute
issue_fire  output  1  issue_valid && !hazard_stall && !stall_all && !flush
pending_mask  output  8  bit r = countdown[r] != 0
stall_count  output  16  saturating count of cycles with hazard_stall=1 and stall_all=0

Behaviour:
- State: cnt[0..7], CNT_W bits each, plus stall_count. Async reset: all cnt=0, stall_count=0. Therefore hazard_stall=0, issue_fire=0 (given inputs), pending_mask=0.
- hazard_stall (combinational from registered cnt) = issue_valid && !flush && ((sr1_used && cnt[sr1_reg]!=0) || (sr2_used && cnt[sr2_reg]!=0)).
- Load class: is_load = byte_read || word_read.
- issue latency value:
  - trap_instr && ld_regfile -> WB_LAT.
  - else is_load && ld_regfile -> LOAD_LAT.
  - else ld_regfile -> 0.
  - no ld_regfile -> dest entry untouched.
- Per clock edge, priority high to low:
  1. flush=1 -> all cnt=0, regardless of stall_all or issue.
  2. stall_all=1 -> all cnt and stall_count hold.
  3. Otherwise every nonzero cnt decrements by 1. Then, if issue_fire and ld_regfile, cnt[dest_reg] is loaded with its issue latency value; the load overrides the decrement of that same entry (WAW: the newest writer wins, including an ALU writer clearing a pending load).
- Self-dependency (sr == dest) checks the old cnt; the instruction's own update lands on the same edge it issues.
- Timing with LOAD_LAT=2: load issues at T; dependent in decode at T+1 and T+2 sees stall; it issues at T+3.
- stall_count increments by 1 when hazard_stall && !stall_all && !flush; it saturates at 16'hFFFF and clears only on reset.
- Reset asserted mid-countdown clears all state immediately (asynchronously). No stall is held after release.
- Register 7 written by a trap uses WB_LAT like any other destination. No special case.

Test Plan:
- Reset, then ADD R1 issue followed by ADD R2,R1,R1 -> hazard_stall=0 both cycles, pending_mask stays 8'h00.
- LDR R3 issue at T, then ADD R4,R3,#1 held in decode -> hazard_stall=1 at T+1 and T+2, issue_fire=1 at T+3, pending_mask=8'h08 at T+1, stall_count=2.
- TRAP (dest R7) at T, then JMP R7 -> stall at T+1..T+3, issue at T+4, pending_mask bit7 counts 3,2,1,0.
- LDR R3 at T, ADD R3 (ALU, no sources pending) at T+1, reader of R3 at T+2 -> no stall at T+2, because the WAW overwrite set cnt[3]=0.
- LDR R5 at T, stall_all=1 for cycles T+1..T+4, reader of R5 in decode -> cnt[5] frozen at 2, hazard_stall stays 1, stall_count unchanged; after release the reader issues 2 cycles later.
- LDR R2 at T, flush at T+1 -> pending_mask=0 at T+2, reader of R2 issues without stall. Also: reset_n pulsed low mid-count -> all outputs 0 asynchronously.
